// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues reads to a
// synchronous-read instruction memory (one-cycle latency), buffers up to two
// returned words in a small FIFO and presents the head entry to decode over a
// valid/ready handshake. A branch redirect flushes the buffer and restarts
// fetch at a new address. The op/func fields of the head instruction are
// broken out, and pairs the control unit does not implement are flagged.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   imem_en      out  1       read request to instruction memory this cycle
//   imem_addr    out  ADDR_W  word address of the request
//   imem_rdata   in   32      read data, valid the cycle after imem_en
//   redirect     in   1       branch taken; restart fetch at redirect_pc
//   redirect_pc  in   ADDR_W  new fetch address
//   out_valid    out  1       instr/op/func/pc/illegal hold a valid instruction
//   out_ready    in   1       decode accepts the presented instruction
//   instr        out  32      instruction word (buffer head)
//   op           out  6       instr[31:26]
//   func         out  6       instr[5:0]
//   pc           out  ADDR_W  word address of instr
//   illegal      out  1       op/func pair not supported (0 when empty)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [ADDR_W-1:0] pc,
    output logic              illegal
);

    // RUN  : responses are written into the buffer as they return.
    // DROP : the response returning this cycle belongs to a flushed stream.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetchState_t;

    fetchState_t       state_r;
    fetchState_t       stateNext_s;

    // Fetch side
    logic [ADDR_W-1:0] fetchPc_r;
    logic              inflight_r;     // a response is on imem_rdata this cycle
    logic [ADDR_W-1:0] inflightPc_r;   // address that response belongs to

    // Two-entry FIFO, head entry drives the outputs
    logic [1:0]        count_r;
    logic [31:0]       headInstr_r;
    logic [ADDR_W-1:0] headPc_r;
    logic [31:0]       tailInstr_r;
    logic [ADDR_W-1:0] tailPc_r;

    // Per-cycle control
    logic              pop_s;
    logic              push_s;
    logic              discard_s;
    logic              issue_s;
    logic [2:0]        occupancy_s;

    // Returns 1 when the control unit implements this op/func combination.
    function automatic logic isSupported(input logic [5:0] opF,
                                         input logic [5:0] funcF);
        logic ok;
        ok = 1'b0;
        case (opF)
            6'b000000: begin
                // R-type: add, sub, and, or, xor
                case (funcF)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b100110: ok = 1'b1;
                    default:              ok = 1'b0;
                endcase
            end
            // lw, sw, beq, lui: func bits are immediate data
            6'b100011, 6'b101011, 6'b000100, 6'b001111: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Issue and handshake control
    // ------------------------------------------------------------------

    // Handshake, buffer write qualification and the issue rule.
    always_comb begin
        pop_s = (count_r != 2'd0) && out_ready;

        // A response lands in the buffer unless it belongs to a flushed
        // stream, either through DROP or through a redirect this cycle.
        if (redirect) begin
            push_s = 1'b0;
        end else begin
            push_s = inflight_r && !discard_s;
        end

        // Entries the buffer will hold at the end of this cycle, counting
        // the response currently returning. A new request only issues when
        // its response (arriving next cycle) is guaranteed a free slot.
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

        if (rst || redirect) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (occupancy_s < 3'd2);
        end
    end

    // ------------------------------------------------------------------
    // Discard state machine
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next state: any redirect seen while a response is outstanding sends
    // the next cycle into DROP; DROP lasts exactly one cycle unless
    // re-triggered.
    always_comb begin
        stateNext_s = RUN;
        case (state_r)
            RUN: begin
                if (redirect && inflight_r) begin
                    stateNext_s = DROP;
                end else begin
                    stateNext_s = RUN;
                end
            end
            DROP: begin
                if (redirect && inflight_r) begin
                    stateNext_s = DROP;
                end else begin
                    stateNext_s = RUN;
                end
            end
            default: stateNext_s = RUN;
        endcase
    end

    // State outputs.
    always_comb begin
        discard_s = 1'b0;
        case (state_r)
            RUN:     discard_s = 1'b0;
            DROP:    discard_s = 1'b1;
            default: discard_s = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch address and outstanding request tracking
    // ------------------------------------------------------------------

    // Program counter and the in-flight marker. Redirect overrides the
    // increment; issue is already suppressed during a redirect so nothing
    // issued this cycle can be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_r    <= RESET_PC;
            inflight_r   <= 1'b0;
            inflightPc_r <= RESET_PC;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflightPc_r <= fetchPc_r;
            end else begin
                inflightPc_r <= inflightPc_r;
            end
            if (redirect) begin
                fetchPc_r <= redirect_pc;
            end else if (issue_s) begin
                // Natural wrap at 2^ADDR_W
                fetchPc_r <= fetchPc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                fetchPc_r <= fetchPc_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-entry instruction buffer
    // ------------------------------------------------------------------

    // Shift-style FIFO: the head register always holds the oldest entry so
    // the outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 2'd0;
            headInstr_r <= 32'h0000_0000;
            headPc_r    <= {ADDR_W{1'b0}};
            tailInstr_r <= 32'h0000_0000;
            tailPc_r    <= {ADDR_W{1'b0}};
        end else if (redirect) begin
            // Flush; a handshake this cycle is still honoured upstream
            // because decode already sampled the head.
            count_r <= 2'd0;
        end else begin
            case ({pop_s, push_s})
                2'b11: begin
                    if (count_r == 2'd1) begin
                        headInstr_r <= imem_rdata;
                        headPc_r    <= inflightPc_r;
                    end else begin
                        headInstr_r <= tailInstr_r;
                        headPc_r    <= tailPc_r;
                        tailInstr_r <= imem_rdata;
                        tailPc_r    <= inflightPc_r;
                    end
                end
                2'b10: begin
                    headInstr_r <= tailInstr_r;
                    headPc_r    <= tailPc_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd0) begin
                        headInstr_r <= imem_rdata;
                        headPc_r    <= inflightPc_r;
                    end else begin
                        tailInstr_r <= imem_rdata;
                        tailPc_r    <= inflightPc_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign imem_en   = issue_s;
    assign imem_addr = fetchPc_r;
    assign out_valid = (count_r != 2'd0);
    assign instr     = headInstr_r;
    assign pc        = headPc_r;
    assign op        = headInstr_r[31:26];
    assign func      = headInstr_r[5:0];
    assign illegal   = out_valid && !isSupported(headInstr_r[31:26], headInstr_r[5:0]);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Randomised bench for instr_fetch_unit. A reference model tracks the stream
// of requests as (address, issue cycle) pairs: an entry becomes deliverable
// two cycles after issue, requests may only issue while fewer than two are
// outstanding after this cycle's handshake, and a redirect discards the whole
// outstanding stream. Inputs change and outputs are sampled just after the
// falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int         ADDR_W   = 8;
    localparam logic [7:0] RESET_PC = 8'hFE;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [7:0]  pc;
    logic        illegal;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .op(op), .func(func), .pc(pc), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle synchronous read, junk when not enabled.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        else         imem_rdata <= $urandom;
    end

    typedef struct {
        logic [7:0] addr;
        int         cyc;
    } req_t;

    req_t        reqQ[$];
    logic [7:0]  nextReqPc;
    int          cyc;
    logic [7:0]  logPc[$];
    logic        logIll[$];
    int          checksTotal;
    int          checksPassed;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic refLegal(input logic [31:0] w);
        logic [5:0] o;
        logic [5:0] f;
        o = w[31:26];
        f = w[5:0];
        return ((o == 6'h00) && (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26}))
            || (o inside {6'h23, 6'h2B, 6'h04, 6'h0F});
    endfunction

    // One clock cycle: drive inputs, check against the model, advance.
    task automatic step(input logic r, input logic [7:0] rpc, input logic rdy);
        logic        expValid;
        logic        expEn;
        logic        popNow;
        int          occ;
        logic [31:0] w;
        redirect    = r;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
        expValid = (reqQ.size() > 0) && (reqQ[0].cyc <= cyc - 2);
        checkVal("out_valid", out_valid, expValid);
        if (expValid) begin
            w = mem[reqQ[0].addr];
            checkVal("pc", pc, reqQ[0].addr);
            checkVal("instr", instr, w);
            checkVal("op", op, w[31:26]);
            checkVal("func", func, w[5:0]);
            checkVal("illegal", illegal, !refLegal(w));
        end else begin
            checkVal("illegal_idle", illegal, 1'b0);
        end
        popNow = expValid && rdy;
        if (popNow) begin
            logPc.push_back(pc);
            logIll.push_back(illegal);
        end
        occ   = reqQ.size() - (popNow ? 1 : 0);
        expEn = !r && (occ < 2);
        checkVal("imem_en", imem_en, expEn);
        if (expEn) checkVal("imem_addr", imem_addr, nextReqPc);
        @(posedge clk);
        if (popNow) void'(reqQ.pop_front());
        if (r) begin
            reqQ.delete();
            nextReqPc = rpc;
        end else if (expEn) begin
            reqQ.push_back('{nextReqPc, cyc});
            nextReqPc = nextReqPc + 8'd1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // One-cycle reset pulse in the middle of traffic.
    task automatic midReset();
        rst = 1'b1;
        #1;
        checkVal("rst_out_valid", out_valid, 1'b0);
        checkVal("rst_imem_en", imem_en, 1'b0);
        checkVal("rst_imem_addr", imem_addr, RESET_PC);
        checkVal("rst_illegal", illegal, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reqQ.delete();
        nextReqPc = RESET_PC;
        cyc = 0;
    endtask

    initial begin
        int n;
        int delivered;
        checksTotal  = 0;
        checksPassed = 0;
        cyc          = 0;
        nextReqPc    = RESET_PC;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 0) mem[i] = $urandom;
            else mem[i] = {6'h00, 20'($urandom), 6'h20 + 6'($urandom_range(0, 6))};
        end
        mem[0] = 32'h0022_1820;  // add
        mem[1] = 32'h8C43_0004;  // lw
        mem[2] = 32'h0022_1821;  // addu: not supported
        mem[3] = 32'h3C01_ABCD;  // lui

        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset_out_valid", out_valid, 1'b0);
        checkVal("reset_imem_en", imem_en, 1'b0);
        checkVal("reset_imem_addr", imem_addr, RESET_PC);
        checkVal("reset_instr", instr, 32'h0000_0000);
        checkVal("reset_pc", pc, 8'h00);
        checkVal("reset_illegal", illegal, 1'b0);
        rst = 1'b0;

        // Straight-line fetch from 0xFE across the wrap, full throughput
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
        checkVal("stream_count", logPc.size(), 32'd10);
        checkVal("wrap_pc0", logPc[0], 8'hFE);
        checkVal("wrap_pc1", logPc[1], 8'hFF);
        checkVal("wrap_pc2", logPc[2], 8'h00);
        checkVal("wrap_pc3", logPc[3], 8'h01);
        checkVal("add_legal", logIll[2], 1'b0);
        checkVal("lw_legal", logIll[3], 1'b0);
        checkVal("addu_illegal", logIll[4], 1'b1);
        checkVal("lui_legal", logIll[5], 1'b0);

        // Backpressure: restart at 0, stall decode, then release
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
        n = logPc.size();
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        checkVal("bp_count", logPc.size() - n, 32'd4);
        for (int i = 0; i < 4; i++) checkVal("bp_seq", logPc[n+i], i);

        // Redirect to 0x40 while pc=3 is presented and accepted
        step(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        n = logPc.size();
        step(1'b1, 8'h40, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        checkVal("redir_gap", logPc.size() - n, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        checkVal("redir_last", logPc[n], 8'h03);
        checkVal("redir_first", logPc[n+1], 8'h40);

        // Back-to-back redirects: the last target wins
        step(1'b1, 8'h10, 1'b1);
        step(1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // Reset while the buffer is full
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
        midReset();
        n = logPc.size();
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        checkVal("rst_refetch", logPc[n], RESET_PC);

        // Throughput with out_ready held high
        n = logPc.size();
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
        delivered = logPc.size() - n;
        checkVal("throughput", delivered, 32'd40);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) midReset();
            else step($urandom_range(0, 15) == 0, 8'($urandom),
                      $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
